command_issue_control: RTL and testbench

// - PSL command-issue stage sitting directly upstream of the tag FIFO/bookkeeping block.
// - Accepts one command per cycle from the CU command arbiter.
// - Pops a free tag from the tag FIFO and records the request's CommandTagLine against that tag.
// - Drives the registered PSL command interface (ah_c*) with odd parity.
// - Gates issue on tag availability and on PSL command credits (ha_croom).
// - Credits are returned on each PSL response.

---
 rtl/command_issue_control.sv | 120 ++++++++++++
 tb/tb_command_issue_control.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/command_issue_control.sv
// Command-issue stage ahead of the tag FIFO / bookkeeping block.
// Accepts one command per cycle from the CU arbiter, pops a free tag and
// presents a registered PSL command (ah_c*) with odd parity one cycle later.
// Issue is gated on tag availability and on PSL command credits.
module command_issue_control #(
  parameter int unsigned       CMD_WIDTH    = 13,
  parameter int unsigned       ADDR_WIDTH   = 64,
  parameter int unsigned       SIZE_WIDTH   = 12,
  parameter int unsigned       TAGID_WIDTH  = 32,
  parameter int unsigned       CREDIT_WIDTH = 8,
  parameter logic [2:0]        CMD_ABT      = 3'b000
) (
  input  logic                    clock,
  input  logic                    rstn,
  input  logic                    enabled,
  input  logic [7:0]              ha_croom,
  input  logic                    cmd_in_valid,
  output logic                    cmd_in_ready,
  input  logic [CMD_WIDTH-1:0]    cmd_in_command,
  input  logic [ADDR_WIDTH-1:0]   cmd_in_address,
  input  logic [SIZE_WIDTH-1:0]   cmd_in_size,
  input  logic [TAGID_WIDTH-1:0]  cmd_in_tag_id,
  input  logic                    tag_buffer_ready,
  input  logic [7:0]              command_tag,
  output logic                    tag_command_valid,
  output logic [TAGID_WIDTH-1:0]  tag_command_id,
  input  logic                    response_valid,
  output logic                    ah_cvalid,
  output logic [CMD_WIDTH-1:0]    ah_com,
  output logic                    ah_compar,
  output logic [ADDR_WIDTH-1:0]   ah_cea,
  output logic                    ah_ceapar,
  output logic [7:0]              ah_ctag,
  output logic                    ah_ctagpar,
  output logic [SIZE_WIDTH-1:0]   ah_csize,
  output logic [2:0]              ah_cabt,
  output logic [CREDIT_WIDTH-1:0] credits,
  output logic                    credit_error
);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN
  } state_t;

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = '1;

  state_t                  state;
  logic [CREDIT_WIDTH-1:0] credit_count;
  logic                    accept;

  // Ready is independent of cmd_in_valid; enabled is deliberately not used so
  // that a command accepted on the disabling edge is still issued.
  always_comb begin
    cmd_in_ready      = (state == RUN) && tag_buffer_ready && (credit_count != '0);
    accept            = cmd_in_valid && cmd_in_ready;
    tag_command_valid = accept;
    tag_command_id    = cmd_in_tag_id;
    credits           = credit_count;
    ah_cabt           = CMD_ABT;
  end

  // Control FSM with credit accounting; credit_error is sticky until rstn.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      credit_count <= '0;
      credit_error <= 1'b0;
    end else if (!enabled) begin
      state        <= IDLE;
      credit_count <= '0;
    end else begin
      case (state)
        IDLE: state <= INIT;
        INIT: begin
          credit_count <= CREDIT_WIDTH'(ha_croom);
          state        <= RUN;
        end
        RUN: begin
          // Net of issue and return: simultaneous accept and response cancel.
          if (accept && !response_valid) begin
            if (credit_count == '0) credit_error <= 1'b1;
            else                    credit_count <= credit_count - 1'b1;
          end else if (response_valid && !accept) begin
            if (credit_count == CREDIT_MAX) credit_error <= 1'b1;
            else                            credit_count <= credit_count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered PSL command; payload holds its last value when nothing issues.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      ah_cvalid  <= 1'b0;
      ah_com     <= '0;
      ah_compar  <= 1'b0;
      ah_cea     <= '0;
      ah_ceapar  <= 1'b0;
      ah_ctag    <= '0;
      ah_ctagpar <= 1'b0;
      ah_csize   <= '0;
    end else begin
      ah_cvalid <= accept;
      if (accept) begin
        ah_com     <= cmd_in_command;
        ah_compar  <= ~^cmd_in_command;
        ah_cea     <= cmd_in_address;
        ah_ceapar  <= ~^cmd_in_address;
        ah_ctag    <= command_tag;
        ah_ctagpar <= ~^command_tag;
        ah_csize   <= cmd_in_size;
      end
    end
  end

endmodule

// File: tb/tb_command_issue_control.sv
// Bench for command_issue_control: table-driven cycle vectors with a
// scoreboard queue of expected PSL commands, plus hand sequences for
// parity, credit saturation, disable and reset.
module tb_command_issue_control;

  logic        clock = 1'b0;
  logic        rstn;
  logic        enabled;
  logic [7:0]  ha_croom;
  logic        cmd_in_valid;
  logic        cmd_in_ready;
  logic [12:0] cmd_in_command;
  logic [63:0] cmd_in_address;
  logic [11:0] cmd_in_size;
  logic [31:0] cmd_in_tag_id;
  logic        tag_buffer_ready;
  logic [7:0]  command_tag;
  logic        tag_command_valid;
  logic [31:0] tag_command_id;
  logic        response_valid;
  logic        ah_cvalid;
  logic [12:0] ah_com;
  logic        ah_compar;
  logic [63:0] ah_cea;
  logic        ah_ceapar;
  logic [7:0]  ah_ctag;
  logic        ah_ctagpar;
  logic [11:0] ah_csize;
  logic [2:0]  ah_cabt;
  logic [7:0]  credits;
  logic        credit_error;

  command_issue_control #(
    .CMD_WIDTH(13), .ADDR_WIDTH(64), .SIZE_WIDTH(12), .TAGID_WIDTH(32),
    .CREDIT_WIDTH(8), .CMD_ABT(3'b000)
  ) dut (
    .clock(clock), .rstn(rstn), .enabled(enabled), .ha_croom(ha_croom),
    .cmd_in_valid(cmd_in_valid), .cmd_in_ready(cmd_in_ready),
    .cmd_in_command(cmd_in_command), .cmd_in_address(cmd_in_address),
    .cmd_in_size(cmd_in_size), .cmd_in_tag_id(cmd_in_tag_id),
    .tag_buffer_ready(tag_buffer_ready), .command_tag(command_tag),
    .tag_command_valid(tag_command_valid), .tag_command_id(tag_command_id),
    .response_valid(response_valid), .ah_cvalid(ah_cvalid),
    .ah_com(ah_com), .ah_compar(ah_compar), .ah_cea(ah_cea), .ah_ceapar(ah_ceapar),
    .ah_ctag(ah_ctag), .ah_ctagpar(ah_ctagpar), .ah_csize(ah_csize),
    .ah_cabt(ah_cabt), .credits(credits), .credit_error(credit_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        en, valid, tbr, resp;
    logic [12:0] cmd;
    logic [63:0] addr;
    logic [11:0] size;
    logic [31:0] tagid;
    logic [7:0]  ctag;
    logic        exp_ready;
    logic [7:0]  exp_credits;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [12:0] cmd;
    logic [63:0] addr;
    logic [11:0] size;
    logic [7:0]  ctag;
  } issue_t;

  issue_t sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic valid, input logic tbr,
                              input logic resp, input logic [7:0] ctag,
                              input logic exp_ready, input logic [7:0] exp_cr,
                              input logic exp_err);
    vec_t v;
    v.en = en; v.valid = valid; v.tbr = tbr; v.resp = resp; v.ctag = ctag;
    v.cmd   = 13'($urandom);
    v.addr  = {$urandom, $urandom};
    v.size  = 12'($urandom);
    v.tagid = $urandom;
    v.exp_ready = exp_ready; v.exp_credits = exp_cr; v.exp_err = exp_err;
    return v;
  endfunction

  // Called one time unit after a rising edge: drive, check combinational
  // outputs mid-cycle, then check registered outputs just after the edge.
  task automatic step(input vec_t v, input string nm);
    issue_t it;
    enabled          = v.en;
    cmd_in_valid     = v.valid;
    tag_buffer_ready = v.tbr;
    response_valid   = v.resp;
    cmd_in_command   = v.cmd;
    cmd_in_address   = v.addr;
    cmd_in_size      = v.size;
    cmd_in_tag_id    = v.tagid;
    command_tag      = v.ctag;
    #3;
    check({nm, ".ready"}, 64'(cmd_in_ready), 64'(v.exp_ready));
    check({nm, ".tcvalid"}, 64'(tag_command_valid), 64'(v.valid & v.exp_ready));
    if (v.valid && v.exp_ready) begin
      check({nm, ".tcid"}, 64'(tag_command_id), 64'(v.tagid));
      it.cmd = v.cmd; it.addr = v.addr; it.size = v.size; it.ctag = v.ctag;
      sb.push_back(it);
    end
    @(posedge clock);
    #1;
    if (sb.size() > 0) begin
      it = sb.pop_front();
      check({nm, ".cvalid"}, 64'(ah_cvalid), 64'd1);
      check({nm, ".com"}, 64'(ah_com), 64'(it.cmd));
      check({nm, ".cea"}, ah_cea, it.addr);
      check({nm, ".csize"}, 64'(ah_csize), 64'(it.size));
      check({nm, ".ctag"}, 64'(ah_ctag), 64'(it.ctag));
      check({nm, ".compar"}, 64'(ah_compar), 64'(~^it.cmd));
      check({nm, ".ceapar"}, 64'(ah_ceapar), 64'(~^it.addr));
      check({nm, ".ctagpar"}, 64'(ah_ctagpar), 64'(~^it.ctag));
    end else begin
      check({nm, ".cvalid"}, 64'(ah_cvalid), 64'd0);
    end
    check({nm, ".credits"}, 64'(credits), 64'(v.exp_credits));
    check({nm, ".cerr"}, 64'(credit_error), 64'(v.exp_err));
  endtask

  vec_t tbl[15];
  vec_t v;

  initial begin
    rstn = 1'b0; enabled = 1'b0; ha_croom = 8'd4; cmd_in_valid = 1'b0;
    cmd_in_command = '0; cmd_in_address = '0; cmd_in_size = '0; cmd_in_tag_id = '0;
    tag_buffer_ready = 1'b0; command_tag = '0; response_valid = 1'b0;

    //          en valid tbr resp ctag  rdy cred err
    tbl[0]  = mk(1, 0, 1, 0, 8'h00, 0, 8'd0, 0);  // IDLE -> INIT
    tbl[1]  = mk(1, 0, 1, 1, 8'h00, 0, 8'd4, 0);  // INIT loads croom, response ignored
    tbl[2]  = mk(1, 1, 1, 0, 8'h01, 1, 8'd3, 0);  // 6 back-to-back, 4 credits
    tbl[3]  = mk(1, 1, 1, 0, 8'h02, 1, 8'd2, 0);
    tbl[4]  = mk(1, 1, 1, 0, 8'h03, 1, 8'd1, 0);
    tbl[5]  = mk(1, 1, 1, 0, 8'h04, 1, 8'd0, 0);
    tbl[6]  = mk(1, 1, 1, 0, 8'h05, 0, 8'd0, 0);  // out of credits
    tbl[7]  = mk(1, 1, 1, 0, 8'h06, 0, 8'd0, 0);
    tbl[8]  = mk(1, 0, 1, 1, 8'h05, 0, 8'd1, 0);  // one credit returned
    tbl[9]  = mk(1, 1, 1, 0, 8'h05, 1, 8'd0, 0);  // tag 0x05 issued
    tbl[10] = mk(1, 0, 1, 1, 8'h00, 0, 8'd1, 0);
    tbl[11] = mk(1, 0, 1, 1, 8'h00, 1, 8'd2, 0);
    tbl[12] = mk(1, 1, 1, 1, 8'h07, 1, 8'd2, 0);  // accept + response: net 0
    tbl[13] = mk(1, 1, 0, 0, 8'h08, 0, 8'd2, 0);  // no tag available
    tbl[14] = mk(1, 1, 1, 0, 8'h00, 1, 8'd1, 0);  // parity vector
    tbl[14].cmd  = 13'h0A00;
    tbl[14].addr = 64'h1;

    #12;
    check("rst.cvalid", 64'(ah_cvalid), 64'd0);
    check("rst.com", 64'(ah_com), 64'd0);
    check("rst.cea", ah_cea, 64'd0);
    check("rst.ctag", 64'(ah_ctag), 64'd0);
    check("rst.pars", 64'({ah_compar, ah_ceapar, ah_ctagpar}), 64'd0);
    check("rst.cabt", 64'(ah_cabt), 64'd0);
    check("rst.credits", 64'(credits), 64'd0);
    check("rst.cerr", 64'(credit_error), 64'd0);
    check("rst.ready", 64'(cmd_in_ready), 64'd0);
    check("rst.tcvalid", 64'(tag_command_valid), 64'd0);
    @(posedge clock);
    #1 rstn = 1'b1;

    for (int i = 0; i < 15; i++) step(tbl[i], $sformatf("v%0d", i));

    check("par.compar", 64'(ah_compar), 64'd1);
    check("par.ceapar", 64'(ah_ceapar), 64'd0);
    check("par.ctagpar", 64'(ah_ctagpar), 64'd1);

    // Payload holds after an idle cycle.
    step(mk(1, 0, 1, 0, 8'h33, 1, 8'd1, 0), "hold");
    check("hold.com", 64'(ah_com), 64'h0A00);
    check("hold.cea", ah_cea, 64'h1);

    // Fill credits up to the maximum.
    for (int i = 0; i < 254; i++) step(mk(1, 0, 1, 1, 8'h00, 1, 8'(i + 2), 0), "fill");
    step(mk(1, 0, 1, 1, 8'h00, 1, 8'd255, 1), "ovf");
    step(mk(1, 0, 1, 0, 8'h00, 1, 8'd255, 1), "ovf_hold");

    // Disable with a command in flight: it is still presented, then nothing.
    step(mk(0, 1, 1, 0, 8'h5A, 1, 8'd0, 1), "dis0");
    step(mk(0, 1, 1, 0, 8'h5B, 0, 8'd0, 1), "dis1");
    step(mk(1, 1, 1, 0, 8'h5C, 0, 8'd0, 1), "reidle");

    rstn = 1'b0;
    #2;
    check("rst2.cerr", 64'(credit_error), 64'd0);
    check("rst2.credits", 64'(credits), 64'd0);
    check("rst2.cvalid", 64'(ah_cvalid), 64'd0);
    rstn = 1'b1;

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb.leftover: got %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
